seg_stepper_fsm: RTL and testbench

Parametrised state-stepping FSM with on-chip tick divider, input synchroniser and hex seven-segment output. It divides the system clock into a slow step tick and, on each tick, moves a modulo-N state up or down under control of input `x`. The current state is driven to a single active-low seven-segment digit. It sits between the board switch inputs and the display pins, and generalises the fixed 4-state display FSM to N states with direction, load and wrap reporting.

---
 rtl/seg_stepper_fsm.sv | 175 +++++++++++++++++
 tb/tb_seg_stepper_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_stepper_fsm.sv
// -----------------------------------------------------------------------------
// seg_stepper_fsm
//
// Steps a modulo-N state up or down once per slow tick and shows the current
// state on one active-low seven-segment digit (hex glyphs 0..F).
//
// The system clock is divided by DIV into a one-cycle step tick. On a tick
// with en high, the state moves up (x = 1) or down (x = 0) and wraps at the
// ends of 0..N-1. A load strobe overrides stepping in any cycle.
//
// Parameters
//   DIV : system-clock cycles per step tick (2 .. 2**27)
//   N   : number of states (2 .. 16); states are 0..N-1
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   x        in   asynchronous direction switch, 1 = up, 0 = down
//   en       in   step enable, only looked at on tick cycles
//   load     in   load strobe, takes effect on the next edge
//   load_val in   value to load; values >= N load 0
//   state    out  current state, registered
//   seg      out  {a,b,c,d,e,f,g}, active-low, registered with state
//   tick     out  one-cycle pulse per step period
//   wrap     out  one-cycle pulse when a step wraps around the ends
// -----------------------------------------------------------------------------
module seg_stepper_fsm #(
  parameter int DIV = 20000000,
  parameter int N   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] state,
  output logic [6:0] seg,
  output logic       tick,
  output logic       wrap
);

  localparam logic [26:0] DIV_LAST = 27'(DIV - 1);
  localparam logic [3:0]  LAST     = 4'(N - 1);
  // One bit wider than the state so that N = 16 is representable.
  localparam logic [4:0]  N_W      = 5'(N);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_UP,
    ACT_DOWN
  } act_e;

  logic [26:0] div_cnt_q, div_cnt_d;
  logic        step_now;
  logic        tick_q;
  logic        x_meta_q, x_s_q;
  logic [3:0]  state_q, state_d;
  logic [6:0]  seg_q, seg_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  cur;
  act_e        act;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // ---- tick divider ---------------------------------------------------------
  assign step_now  = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = step_now ? 27'd0 : div_cnt_q + 27'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= 27'd0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= step_now;
    end
  end

  // ---- direction synchroniser -----------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_meta_q <= 1'b0;
      x_s_q    <= 1'b0;
    end else begin
      x_meta_q <= x;
      x_s_q    <= x_meta_q;
    end
  end

  // ---- next state and display decode ----------------------------------------
  always_comb begin
    act     = ACT_HOLD;
    cur     = (state_q <= LAST) ? state_q : 4'd0;
    state_d = cur;
    wrap_d  = 1'b0;

    if (load) begin
      act = ACT_LOAD;
    end else if (step_now && en) begin
      act = x_s_q ? ACT_UP : ACT_DOWN;
    end

    // cur already folds any out-of-range state back to 0, so holding also
    // repairs a corrupted register on the next edge.
    case (act)
      ACT_LOAD: begin
        state_d = ({1'b0, load_val} < N_W) ? load_val : 4'd0;
      end
      ACT_UP: begin
        if (cur == LAST) begin
          state_d = 4'd0;
          wrap_d  = 1'b1;
        end else begin
          state_d = cur + 4'd1;
        end
      end
      ACT_DOWN: begin
        if (cur == 4'd0) begin
          state_d = LAST;
          wrap_d  = 1'b1;
        end else begin
          state_d = cur - 4'd1;
        end
      end
      default: begin
        state_d = cur;
      end
    endcase

    // Decoding the next state lets seg register on the same edge as state.
    seg_d = seg_decode(state_d);
  end

  // ---- state / display registers --------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 4'd0;
      seg_q   <= 7'b0000001;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state = state_q;
  assign seg   = seg_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_seg_stepper_fsm.sv
module tb_seg_stepper_fsm;

  localparam int DIV = 4;

  typedef struct {
    logic [3:0] st;
    logic       wr;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_v  [3];
  logic       x_v    [3];
  logic       en_v   [3];
  logic       load_v [3];
  logic [3:0] lv_v   [3];
  logic [3:0] st_v   [3];
  logic [6:0] seg_v  [3];
  logic       tick_v [3];
  logic       wrap_v [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_chk;
  int n_fail;
  int cyc;
  int rref [3];
  int last [3];

  seg_stepper_fsm #(.DIV(DIV), .N(4)) dut0 (
    .clk(clk), .rst(rst_v[0]), .x(x_v[0]), .en(en_v[0]), .load(load_v[0]),
    .load_val(lv_v[0]), .state(st_v[0]), .seg(seg_v[0]), .tick(tick_v[0]),
    .wrap(wrap_v[0]));

  seg_stepper_fsm #(.DIV(DIV), .N(10)) dut1 (
    .clk(clk), .rst(rst_v[1]), .x(x_v[1]), .en(en_v[1]), .load(load_v[1]),
    .load_val(lv_v[1]), .state(st_v[1]), .seg(seg_v[1]), .tick(tick_v[1]),
    .wrap(wrap_v[1]));

  seg_stepper_fsm #(.DIV(DIV), .N(16)) dut2 (
    .clk(clk), .rst(rst_v[2]), .x(x_v[2]), .en(en_v[2]), .load(load_v[2]),
    .load_val(lv_v[2]), .state(st_v[2]), .seg(seg_v[2]), .tick(tick_v[2]),
    .wrap(wrap_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered glyph table, abcdefg active-low.
  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [3:0] st, input logic wr, input string tag);
    exp_t e;
    e.st = st; e.wr = wr; e.tag = tag;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int k, output exp_t e, output bit ok);
    ok = 1'b1;
    e.st = 4'd0; e.wr = 1'b0; e.tag = "";
    case (k)
      0: if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
    endcase
  endtask

  // Edge counter; remembers the last edge each DUT saw reset high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++)
      if (rst_v[k] === 1'b1) rref[k] <= cyc + 1;
  end

  // Monitor: every tick pulse consumes one expected response.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (tick_v[k] === 1'b1) begin
        exp_t e;
        bit   ok;
        int   ref_c;
        pop(k, e, ok);
        if (!ok) begin
          check($sformatf("dut%0d unexpected tick at cycle %0d", k, cyc), 32'd1, 32'd0);
        end else begin
          check($sformatf("dut%0d %s state", k, e.tag), 32'(st_v[k]), 32'(e.st));
          check($sformatf("dut%0d %s seg", k, e.tag), 32'(seg_v[k]), 32'(exp_seg(e.st)));
          check($sformatf("dut%0d %s wrap", k, e.tag), 32'(wrap_v[k]), 32'(e.wr));
        end
        ref_c = (rref[k] > last[k]) ? rref[k] : last[k];
        check($sformatf("dut%0d tick spacing", k), 32'(cyc - ref_c), 32'(DIV));
        last[k] = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int k);
    check($sformatf("dut%0d reset state", k), 32'(st_v[k]), 32'd0);
    check($sformatf("dut%0d reset seg", k), 32'(seg_v[k]), 32'(7'b0000001));
    check($sformatf("dut%0d reset tick", k), 32'(tick_v[k]), 32'd0);
    check($sformatf("dut%0d reset wrap", k), 32'(wrap_v[k]), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; x_v[k] = 1'b0; en_v[k] = 1'b0;
      load_v[k] = 1'b0; lv_v[k] = 4'd0; rref[k] = 0; last[k] = 0;
    end
    step(2);

    // N=4 counting up, wrap, load priority, enable, direction, mid reset
    x_v[0] = 1'b1; en_v[0] = 1'b1;
    step(1);
    rst_v[0] = 1'b0;
    chk_reset(0);
    push(0, 4'd1, 1'b0, "up t1");
    push(0, 4'd2, 1'b0, "up t2");
    push(0, 4'd3, 1'b0, "up t3");
    push(0, 4'd0, 1'b1, "up wrap");
    push(0, 4'd1, 1'b0, "up t5");
    step(23);
    load_v[0] = 1'b1; lv_v[0] = 4'd2;
    push(0, 4'd2, 1'b0, "load2 on tick");
    step(1);
    load_v[0] = 1'b0;
    push(0, 4'd0, 1'b0, "load0 on tick");
    step(3);
    load_v[0] = 1'b1; lv_v[0] = 4'd0;
    step(1);
    load_v[0] = 1'b0;
    step(1);
    load_v[0] = 1'b1; lv_v[0] = 4'd3;
    push(0, 4'd0, 1'b1, "step after load3");
    step(1);
    load_v[0] = 1'b0;
    push(0, 4'd1, 1'b0, "up from 0");
    step(6);
    en_v[0] = 1'b0;
    push(0, 4'd1, 1'b0, "en low a");
    push(0, 4'd1, 1'b0, "en low b");
    push(0, 4'd1, 1'b0, "en low c");
    step(12);
    en_v[0] = 1'b1;
    push(0, 4'd2, 1'b0, "late x old dir");
    push(0, 4'd1, 1'b0, "late x new dir");
    step(3);
    x_v[0] = 1'b0;
    step(5);
    x_v[0] = 1'b1;
    push(0, 4'd2, 1'b0, "back up 2");
    push(0, 4'd3, 1'b0, "back up 3");
    step(9);
    rst_v[0] = 1'b1;
    step(1);
    rst_v[0] = 1'b0;
    chk_reset(0);
    push(0, 4'd1, 1'b0, "after mid reset");
    step(4);
    rst_v[0] = 1'b1;
    step(2);

    // N=10 counting down from reset, out-of-range load
    x_v[1] = 1'b0; en_v[1] = 1'b1;
    step(1);
    rst_v[1] = 1'b0;
    chk_reset(1);
    push(1, 4'd9, 1'b1, "down wrap");
    push(1, 4'd8, 1'b0, "down");
    step(8);
    load_v[1] = 1'b1; lv_v[1] = 4'd12; en_v[1] = 1'b0;
    step(1);
    load_v[1] = 1'b0;
    push(1, 4'd0, 1'b0, "load 12 clamps");
    step(3);
    rst_v[1] = 1'b1;
    step(2);

    // N=16 load E then count up through F to 0
    x_v[2] = 1'b1; en_v[2] = 1'b0;
    step(1);
    rst_v[2] = 1'b0;
    chk_reset(2);
    load_v[2] = 1'b1; lv_v[2] = 4'hE;
    step(1);
    load_v[2] = 1'b0; en_v[2] = 1'b1;
    push(2, 4'hF, 1'b0, "E to F");
    push(2, 4'h0, 1'b1, "F wraps");
    push(2, 4'h1, 1'b0, "0 to 1");
    step(11);
    rst_v[2] = 1'b1;
    step(2);

    check("dut0 pending responses", 32'(q0.size()), 32'd0);
    check("dut1 pending responses", 32'(q1.size()), 32'd0);
    check("dut2 pending responses", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
